clic_vector: RTL and testbench

- Sits directly downstream of the CLIC, between its `clic_meip`/`clic_meid` outputs and the core's trap entry.
- Per taken machine interrupt, resolves the handler address:
  - selective-hardware-vectored (shv=1): reads one entry of the vector table at mtvt through a memory read port;
  - non-vectored: uses the 64-byte-aligned mtvec base.
- Presents {address, id} to the core on a valid/ready handshake.

---
 rtl/clic_vector.sv | 179 +++++++++++++++++
 tb/tb_clic_vector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_vector.sv
// Turns the CLIC's winning machine interrupt into a handler address and id for the core.
// The address comes from a vector-table read (shv=1) or from the aligned mtvec base (shv=0).
module clic_vector #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clic_meip,
    input  logic [ID_W-1:0]   clic_meid,
    input  logic              clic_shv,
    input  logic              mie,
    input  logic [ADDR_W-1:0] mtvec,
    input  logic [ADDR_W-1:0] mtvt,
    output logic              vec_valid,
    output logic              vec_instr,
    output logic [ADDR_W-1:0] vec_addr,
    output logic [3:0]        vec_wstrb,
    input  logic [ADDR_W-1:0] vec_rdata,
    input  logic              vec_ready,
    output logic              irq_valid,
    output logic [ADDR_W-1:0] irq_addr,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_vec_valid;
    logic [ADDR_W-1:0] r_vec_addr;
    logic              r_irq_valid;
    logic [ADDR_W-1:0] r_irq_addr;
    logic [ID_W-1:0]   r_irq_id;
    logic [ID_W-1:0]   r_id;

    logic              w_vec_valid_nxt;
    logic [ADDR_W-1:0] w_vec_addr_nxt;
    logic              w_irq_valid_nxt;
    logic [ADDR_W-1:0] w_irq_addr_nxt;
    logic [ID_W-1:0]   w_irq_id_nxt;
    logic [ID_W-1:0]   w_id_nxt;

    logic              w_take;
    logic [ADDR_W-1:0] w_mtvec_base;
    logic [ADDR_W-1:0] w_mtvt_base;
    logic [ADDR_W-1:0] w_id_offset;
    logic [ADDR_W-1:0] w_tbl_addr;
    logic              w_unused;

    // Id 0 means "no interrupt" from the CLIC, so it never starts a request.
    assign w_take       = clic_meip & mie & (clic_meid != {ID_W{1'b0}});
    assign w_mtvec_base = {mtvec[ADDR_W-1:6], 6'b000000};
    assign w_mtvt_base  = {mtvt[ADDR_W-1:6], 6'b000000};
    assign w_id_offset  = {{(ADDR_W-ID_W-2){1'b0}}, clic_meid, 2'b00};
    assign w_tbl_addr   = w_mtvt_base + w_id_offset;
    assign w_unused     = ^{mtvec[5:0], mtvt[5:0], vec_rdata[0]};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision; a started fetch or response only ends by handshake or reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt = clic_shv ? FETCH : RESP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (vec_ready) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            RESP: begin
                if (irq_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; CSRs are only looked at on the IDLE decision edge.
    always_comb begin
        w_vec_valid_nxt = r_vec_valid;
        w_vec_addr_nxt  = r_vec_addr;
        w_irq_valid_nxt = r_irq_valid;
        w_irq_addr_nxt  = r_irq_addr;
        w_irq_id_nxt    = r_irq_id;
        w_id_nxt        = r_id;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_id_nxt = clic_meid;
                    if (clic_shv) begin
                        w_vec_valid_nxt = 1'b1;
                        w_vec_addr_nxt  = w_tbl_addr;
                    end else begin
                        w_irq_valid_nxt = 1'b1;
                        w_irq_addr_nxt  = w_mtvec_base;
                        w_irq_id_nxt    = clic_meid;
                    end
                end else begin
                    w_vec_valid_nxt = 1'b0;
                    w_irq_valid_nxt = 1'b0;
                end
            end
            FETCH: begin
                if (vec_ready) begin
                    w_vec_valid_nxt = 1'b0;
                    w_irq_valid_nxt = 1'b1;
                    w_irq_addr_nxt  = {vec_rdata[ADDR_W-1:1], 1'b0};
                    w_irq_id_nxt    = r_id;
                end else begin
                    w_vec_valid_nxt = 1'b1;
                end
            end
            RESP: begin
                if (irq_ready) begin
                    w_irq_valid_nxt = 1'b0;
                end else begin
                    w_irq_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_vec_valid_nxt = 1'b0;
                w_irq_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and latched-id registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vec_valid <= 1'b0;
            r_vec_addr  <= {ADDR_W{1'b0}};
            r_irq_valid <= 1'b0;
            r_irq_addr  <= {ADDR_W{1'b0}};
            r_irq_id    <= {ID_W{1'b0}};
            r_id        <= {ID_W{1'b0}};
        end else begin
            r_vec_valid <= w_vec_valid_nxt;
            r_vec_addr  <= w_vec_addr_nxt;
            r_irq_valid <= w_irq_valid_nxt;
            r_irq_addr  <= w_irq_addr_nxt;
            r_irq_id    <= w_irq_id_nxt;
            r_id        <= w_id_nxt;
        end
    end

    assign vec_valid = r_vec_valid;
    assign vec_addr  = r_vec_addr;
    assign vec_instr = 1'b0;
    assign vec_wstrb = 4'b0000;
    assign irq_valid = r_irq_valid;
    assign irq_addr  = r_irq_addr;
    assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_clic_vector.sv
// Scoreboard bench for clic_vector: expected fetch addresses and trap responses are queued
// when an interrupt is presented and compared when the DUT raises the matching valid.
module tb_clic_vector;

    logic        clock;
    logic        reset;
    logic        clic_meip;
    logic [11:0] clic_meid;
    logic        clic_shv;
    logic        mie;
    logic [31:0] mtvec;
    logic [31:0] mtvt;
    logic        vec_valid;
    logic        vec_instr;
    logic [31:0] vec_addr;
    logic [3:0]  vec_wstrb;
    logic [31:0] vec_rdata;
    logic        vec_ready;
    logic        irq_valid;
    logic [31:0] irq_addr;
    logic [11:0] irq_id;
    logic        irq_ready;

    typedef struct packed {
        logic [31:0] addr;
        logic [11:0] id;
    } irq_exp_t;

    irq_exp_t    irq_q[$];
    logic [31:0] vec_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] held_addr;

    clic_vector #(.ID_W(12), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .clic_meip(clic_meip), .clic_meid(clic_meid), .clic_shv(clic_shv), .mie(mie),
        .mtvec(mtvec), .mtvt(mtvt),
        .vec_valid(vec_valid), .vec_instr(vec_instr), .vec_addr(vec_addr),
        .vec_wstrb(vec_wstrb), .vec_rdata(vec_rdata), .vec_ready(vec_ready),
        .irq_valid(irq_valid), .irq_addr(irq_addr), .irq_id(irq_id), .irq_ready(irq_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait up to budget extra cycles for vec_valid, then compare against the queued address.
    task automatic expect_vec(input string tag, input int budget);
        for (int i = 0; i < budget && !vec_valid; i++) tick();
        check({tag, "_vec_valid"}, {31'd0, vec_valid}, 32'd1);
        if (vec_q.size() == 0) begin
            check({tag, "_vec_queue"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_vec_addr"}, vec_addr, vec_q.pop_front());
        end
    endtask

    // Wait up to budget extra cycles for irq_valid, then compare against the queued response.
    task automatic expect_irq(input string tag, input int budget);
        irq_exp_t e;
        for (int i = 0; i < budget && !irq_valid; i++) tick();
        check({tag, "_irq_valid"}, {31'd0, irq_valid}, 32'd1);
        if (irq_q.size() == 0) begin
            check({tag, "_irq_queue"}, 32'd0, 32'd1);
        end else begin
            e = irq_q.pop_front();
            check({tag, "_irq_addr"}, irq_addr, e.addr);
            check({tag, "_irq_id"}, {20'd0, irq_id}, {20'd0, e.id});
        end
    endtask

    task automatic accept_irq(input string tag);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check({tag, "_irq_drop"}, {31'd0, irq_valid}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        clic_meip = 1'b0;
        clic_meid = 12'd0;
        clic_shv  = 1'b0;
        mie       = 1'b0;
        mtvec     = 32'd0;
        mtvt      = 32'd0;
        vec_rdata = 32'd0;
        vec_ready = 1'b0;
        irq_ready = 1'b0;
        repeat (3) tick();
        check("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("rst_vec_addr", vec_addr, 32'd0);
        check("rst_irq_valid", {31'd0, irq_valid}, 32'd0);
        check("rst_irq_addr", irq_addr, 32'd0);
        check("rst_irq_id", {20'd0, irq_id}, 32'd0);
        check("vec_instr", {31'd0, vec_instr}, 32'd0);
        check("vec_wstrb", {28'd0, vec_wstrb}, 32'd0);
        reset = 1'b1;
        tick();

        // Non-vectored: one-cycle latency, held while not ready, meip drop does not withdraw.
        clic_meip = 1'b1; mie = 1'b1; clic_meid = 12'd5; clic_shv = 1'b0; mtvec = 32'h8000_0043;
        irq_q.push_back('{addr: 32'h8000_0040, id: 12'd5});
        tick();
        expect_irq("nv", 0);
        clic_meip = 1'b0; mtvec = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nv_hold_valid", {31'd0, irq_valid}, 32'd1);
            check("nv_hold_addr", irq_addr, 32'h8000_0040);
        end
        accept_irq("nv");

        // Vectored fetch: meip dropped and mtvt changed right after FETCH entry.
        clic_meip = 1'b1; clic_meid = 12'd3; clic_shv = 1'b1; mtvt = 32'h0000_1000;
        vec_q.push_back(32'h0000_100C);
        irq_q.push_back('{addr: 32'h0000_2000, id: 12'd3});
        tick();
        expect_vec("v", 0);
        clic_meip = 1'b0; clic_meid = 12'd9; mtvt = 32'h0000_5000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("v_hold_vec_valid", {31'd0, vec_valid}, 32'd1);
            check("v_hold_vec_addr", vec_addr, 32'h0000_100C);
            check("v_hold_no_irq", {31'd0, irq_valid}, 32'd0);
        end
        vec_ready = 1'b1; vec_rdata = 32'h0000_2001;
        tick();
        vec_ready = 1'b0; vec_rdata = 32'd0;
        check("v_vec_drop", {31'd0, vec_valid}, 32'd0);
        expect_irq("v", 0);
        accept_irq("v");

        // mie gating, then back-to-back non-vectored requests.
        mie = 1'b0; clic_meip = 1'b1; clic_meid = 12'd7; clic_shv = 1'b0; mtvec = 32'h0000_0040;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mie0_vec_valid", {31'd0, vec_valid}, 32'd0);
            check("mie0_irq_valid", {31'd0, irq_valid}, 32'd0);
        end
        mie = 1'b1;
        irq_q.push_back('{addr: 32'h0000_0040, id: 12'd7});
        tick();
        expect_irq("mie1", 0);
        irq_ready = 1'b1;
        tick();
        check("b2b_idle_gap", {31'd0, irq_valid}, 32'd0);
        irq_q.push_back('{addr: 32'h0000_0040, id: 12'd7});
        tick();
        expect_irq("b2b", 0);
        clic_meip = 1'b0;
        tick();
        irq_ready = 1'b0;
        check("b2b_drop", {31'd0, irq_valid}, 32'd0);

        // Id 0 is never taken.
        clic_meip = 1'b1; clic_meid = 12'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("id0_irq_valid", {31'd0, irq_valid}, 32'd0);
            check("id0_vec_valid", {31'd0, vec_valid}, 32'd0);
        end

        // Asynchronous reset during FETCH; late vec_ready afterwards is ignored.
        clic_meid = 12'd9; clic_shv = 1'b1; mtvt = 32'h0000_3000;
        vec_q.push_back(32'h0000_3024);
        tick();
        expect_vec("rstf", 0);
        clic_meip = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rstf_vec_async", {31'd0, vec_valid}, 32'd0);
        check("rstf_addr_async", vec_addr, 32'd0);
        #1;
        reset = 1'b1;
        tick();
        vec_ready = 1'b1; vec_rdata = 32'h0000_5555;
        tick();
        vec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstf_no_irq", {31'd0, irq_valid}, 32'd0);
            check("rstf_no_vec", {31'd0, vec_valid}, 32'd0);
            tick();
        end

        // Table address wraps modulo 2^32; bit0 of the table entry is cleared.
        clic_meip = 1'b1; clic_meid = 12'h010; clic_shv = 1'b1; mtvt = 32'hFFFF_FFC0;
        vec_q.push_back(32'h0000_0000);
        irq_q.push_back('{addr: 32'h0000_ABCC, id: 12'h010});
        tick();
        expect_vec("wrap", 0);
        clic_meip = 1'b0;
        tick();
        vec_ready = 1'b1; vec_rdata = 32'h0000_ABCD;
        tick();
        vec_ready = 1'b0;
        expect_irq("wrap", 0);
        held_addr = irq_addr;
        tick();
        check("wrap_hold", irq_addr, held_addr);
        accept_irq("wrap");

        check("irq_q_empty", irq_q.size(), 32'd0);
        check("vec_q_empty", vec_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
